// File: rtl/modred_rr_sched.sv
// Round-robin front end that shares one serial Barrett reduction engine among NUM_REQ requesters.
// It accepts one job at a time, starts the engine, and returns a tagged response or a watchdog error.
module modred_rr_sched #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_LENGTH    = 64,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           cfg_we_i,
  input  logic [DATA_LENGTH-1:0]         cfg_q_i,
  input  logic [DATA_LENGTH-1:0]         cfg_q_bl_i,
  input  logic [DATA_LENGTH-1:0]         cfg_mu_i,
  output logic                           cfg_busy_o,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*DATA_LENGTH-1:0] req_x_i,
  output logic                           eng_start_o,
  output logic [DATA_LENGTH-1:0]         eng_x_o,
  output logic [DATA_LENGTH-1:0]         eng_q_o,
  output logic [DATA_LENGTH-1:0]         eng_q_bl_o,
  output logic [DATA_LENGTH-1:0]         eng_mu_o,
  input  logic [DATA_LENGTH-1:0]         eng_result_i,
  input  logic                           eng_valid_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [ID_W-1:0]                rsp_id_o,
  output logic [DATA_LENGTH-1:0]         rsp_data_o,
  output logic                           rsp_err_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ID_W-1:0]        r_rr_ptr;
  logic [ID_W-1:0]        r_tag;
  logic [DATA_LENGTH-1:0] r_cfg_q;
  logic [DATA_LENGTH-1:0] r_cfg_q_bl;
  logic [DATA_LENGTH-1:0] r_cfg_mu;
  logic [DATA_LENGTH-1:0] r_eng_x;
  logic [DATA_LENGTH-1:0] r_eng_q;
  logic [DATA_LENGTH-1:0] r_eng_q_bl;
  logic [DATA_LENGTH-1:0] r_eng_mu;
  logic [DATA_LENGTH-1:0] r_rsp_data;
  logic                   r_rsp_err;
  logic [WD_W-1:0]        r_wdog;

  logic [ID_W-1:0]        w_grant;
  logic                   w_grant_vld;
  int                     w_best;
  logic [DATA_LENGTH-1:0] w_x_sel;
  logic                   w_hs;
  logic                   w_timeout;

  // Distance of requester i from the slot right after the last winner (0 = highest priority).
  function automatic int rr_dist(input int i, input logic [ID_W-1:0] ptr);
    return (i + NUM_REQ - 1 - int'(ptr)) % NUM_REQ;
  endfunction

  always_comb begin
    w_grant     = '0;
    w_grant_vld = 1'b0;
    w_best      = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid_i[i] && (rr_dist(i, r_rr_ptr) < w_best)) begin
        w_best      = rr_dist(i, r_rr_ptr);
        w_grant     = ID_W'(i);
        w_grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    w_x_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == w_grant) begin
        w_x_sel = req_x_i[i*DATA_LENGTH +: DATA_LENGTH];
      end
    end
  end

  assign w_hs      = (r_state == S_IDLE) && w_grant_vld && rst_ni;
  assign w_timeout = ((r_wdog + WD_W'(1)) == WD_W'(TIMEOUT_CYCLES));

  // Ready is gated by reset so no grant is visible while the block is held in reset.
  always_comb begin
    req_ready_o = '0;
    if (w_hs) begin
      req_ready_o[w_grant] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_hs) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (eng_valid_i || w_timeout) w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= ID_W'(NUM_REQ - 1);
      r_tag      <= '0;
      r_cfg_q    <= '0;
      r_cfg_q_bl <= '0;
      r_cfg_mu   <= '0;
      r_eng_x    <= '0;
      r_eng_q    <= '0;
      r_eng_q_bl <= '0;
      r_eng_mu   <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_wdog     <= '0;
    end else begin
      r_state <= w_state_nxt;
      // A job accepted in the same cycle as a config write still sees the old values.
      if ((r_state == S_IDLE) && cfg_we_i) begin
        r_cfg_q    <= cfg_q_i;
        r_cfg_q_bl <= cfg_q_bl_i;
        r_cfg_mu   <= cfg_mu_i;
      end
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_eng_x    <= w_x_sel;
            r_tag      <= w_grant;
            r_rr_ptr   <= w_grant;
            r_eng_q    <= r_cfg_q;
            r_eng_q_bl <= r_cfg_q_bl;
            r_eng_mu   <= r_cfg_mu;
          end
        end
        S_ISSUE: r_wdog <= '0;
        S_WAIT: begin
          r_wdog <= r_wdog + WD_W'(1);
          if (eng_valid_i) begin
            r_rsp_data <= eng_result_i;
            r_rsp_err  <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cfg_busy_o  = (r_state != S_IDLE);
  assign eng_start_o = (r_state == S_ISSUE);
  assign rsp_valid_o = (r_state == S_RESP);
  assign eng_x_o     = r_eng_x;
  assign eng_q_o     = r_eng_q;
  assign eng_q_bl_o  = r_eng_q_bl;
  assign eng_mu_o    = r_eng_mu;
  assign rsp_id_o    = r_tag;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_modred_rr_sched.sv
// Bench for modred_rr_sched: directed jobs, a job-level reference model checked every cycle,
// and hand-computed literal expectations for the key scenarios.
module tb_modred_rr_sched;
  localparam int N   = 4;
  localparam int DL  = 64;
  localparam int IDW = 2;
  localparam int TO  = 8;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            cfg_we_i = 1'b0;
  logic [DL-1:0]   cfg_q_i = '0, cfg_q_bl_i = '0, cfg_mu_i = '0;
  logic            cfg_busy_o;
  logic [N-1:0]    req_valid_i = '0;
  logic [N-1:0]    req_ready_o;
  logic [N*DL-1:0] req_x_i = '0;
  logic            eng_start_o;
  logic [DL-1:0]   eng_x_o, eng_q_o, eng_q_bl_o, eng_mu_o;
  logic [DL-1:0]   eng_result_i = '0;
  logic            eng_valid_i = 1'b0;
  logic            rsp_valid_o;
  logic            rsp_ready_i = 1'b0;
  logic [IDW-1:0]  rsp_id_o;
  logic [DL-1:0]   rsp_data_o;
  logic            rsp_err_o;

  modred_rr_sched #(.NUM_REQ(N), .DATA_LENGTH(DL), .ID_W(IDW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_we_i(cfg_we_i), .cfg_q_i(cfg_q_i), .cfg_q_bl_i(cfg_q_bl_i), .cfg_mu_i(cfg_mu_i),
    .cfg_busy_o(cfg_busy_o),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_x_i(req_x_i),
    .eng_start_o(eng_start_o), .eng_x_o(eng_x_o), .eng_q_o(eng_q_o),
    .eng_q_bl_o(eng_q_bl_o), .eng_mu_o(eng_mu_o),
    .eng_result_i(eng_result_i), .eng_valid_i(eng_valid_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int eng_delay = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
  endtask

  function automatic logic [63:0] mod_ref(input logic [63:0] x, input logic [63:0] q);
    return (q == 0) ? 64'd0 : x % q;
  endfunction

  // Job-level reference model
  int          m_last = N - 1;
  bit          m_busy = 0;
  bit          m_start_due = 0;
  int          m_rsp_cyc = -1;
  int          m_job_id = 0;
  logic [63:0] m_job_x, m_job_q, m_job_bl, m_job_mu;
  logic [63:0] m_cfg_q = 0, m_cfg_bl = 0, m_cfg_mu = 0;
  logic [63:0] m_exp_data = 0;
  bit          m_exp_err = 0;
  int          m_grants[$];
  bit          m_idle_now, m_rv;
  int          m_g;
  logic [N-1:0] m_er;

  initial forever begin
    @(negedge clk_i);
    cyc++;
    if (!rst_ni) begin
      m_last = N - 1; m_busy = 0; m_start_due = 0; m_rsp_cyc = -1;
      m_cfg_q = 0; m_cfg_bl = 0; m_cfg_mu = 0;
    end else begin
      m_idle_now = !m_busy;
      chk("cfg_busy", cfg_busy_o, m_busy);
      m_g = -1;
      if (m_idle_now)
        for (int off = 1; off <= N; off++)
          if (m_g < 0 && req_valid_i[(m_last + off) % N]) m_g = (m_last + off) % N;
      m_er = '0;
      if (m_g >= 0) m_er[m_g] = 1'b1;
      chk("req_ready", req_ready_o, m_er);
      chk("eng_start", eng_start_o, m_start_due);
      if (m_start_due) begin
        if (eng_delay >= 1 && eng_delay <= TO) begin
          m_rsp_cyc = cyc + eng_delay + 1; m_exp_err = 0; m_exp_data = mod_ref(m_job_x, m_job_q);
        end else begin
          m_rsp_cyc = cyc + TO + 1; m_exp_err = 1; m_exp_data = 0;
        end
      end
      if (m_busy) begin
        chk("eng_x", eng_x_o, m_job_x);
        chk("eng_q", eng_q_o, m_job_q);
        chk("eng_q_bl", eng_q_bl_o, m_job_bl);
        chk("eng_mu", eng_mu_o, m_job_mu);
      end
      m_rv = m_busy && m_rsp_cyc >= 0 && cyc >= m_rsp_cyc;
      chk("rsp_valid", rsp_valid_o, m_rv);
      if (m_rv) begin
        chk("rsp_id", rsp_id_o, m_job_id);
        chk("rsp_data", rsp_data_o, m_exp_data);
        chk("rsp_err", rsp_err_o, m_exp_err);
        if (rsp_ready_i) begin m_busy = 0; m_rsp_cyc = -1; end
      end
      m_start_due = 0;
      if (m_g >= 0) begin
        m_job_id = m_g; m_job_x = req_x_i[m_g*DL +: DL];
        m_job_q = m_cfg_q; m_job_bl = m_cfg_bl; m_job_mu = m_cfg_mu;
        m_busy = 1; m_last = m_g; m_start_due = 1; m_grants.push_back(m_g);
      end
      if (cfg_we_i && m_idle_now) begin
        m_cfg_q = cfg_q_i; m_cfg_bl = cfg_q_bl_i; m_cfg_mu = cfg_mu_i;
      end
    end
  end

  // Engine stand-in: answers x mod q eng_delay cycles after start; eng_delay = 0 means it hangs.
  int          e_cnt = 0;
  logic [63:0] e_res = 0;
  initial forever begin
    @(negedge clk_i);
    if (!rst_ni) e_cnt = 0;
    else if (eng_start_o && eng_delay > 0) begin e_cnt = eng_delay; e_res = mod_ref(eng_x_o, eng_q_o); end
    @(posedge clk_i); #1;
    eng_valid_i = 1'b0;
    if (e_cnt > 0 && rst_ni) begin
      e_cnt--;
      if (e_cnt == 0) begin eng_valid_i = 1'b1; eng_result_i = e_res; end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic do_cfg(input logic [63:0] q, input logic [63:0] bl, input logic [63:0] mu);
    cfg_q_i = q; cfg_q_bl_i = bl; cfg_mu_i = mu; cfg_we_i = 1'b1;
    tick(1);
    cfg_we_i = 1'b0;
  endtask

  task automatic send(input int i, input logic [63:0] x);
    bit got = 0;
    req_x_i[i*DL +: DL] = x;
    req_valid_i[i] = 1'b1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk_i);
      if (req_ready_o[i]) got = 1;
    end
    chk("handshake", got, 1);
    @(posedge clk_i); #1;
    req_valid_i[i] = 1'b0;
  endtask

  task automatic get_rsp(input int hold, input int eid, input logic [63:0] edata, input bit eerr);
    bit got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk_i);
      if (rsp_valid_o) got = 1;
    end
    chk("rsp_arrives", got, 1);
    if (got) begin
      chk("lit_rsp_id", rsp_id_o, eid);
      chk("lit_rsp_data", rsp_data_o, edata);
      chk("lit_rsp_err", rsp_err_o, eerr);
    end
    @(posedge clk_i); #1;
    if (hold > 0) tick(hold);
    rsp_ready_i = 1'b1;
    tick(1);
    rsp_ready_i = 1'b0;
  endtask

  int k_lat, n_gr, base;
  bit got_v, idle_v;
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    // Reset state
    tick(2);
    chk("rst_busy", cfg_busy_o, 0);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_start", eng_start_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_eng_q", eng_q_o, 0);
    rst_ni = 1'b1;
    tick(1);

    // Basic job from requester 1
    do_cfg(64'd3329, 64'd12, 64'd5039);
    eng_delay = 3;
    send(1, 64'd10000);
    chk("lit_start_pulse", eng_start_o, 1);
    chk("lit_eng_x", eng_x_o, 64'd10000);
    chk("lit_eng_q", eng_q_o, 64'd3329);
    chk("lit_eng_bl", eng_q_bl_o, 64'd12);
    chk("lit_eng_mu", eng_mu_o, 64'd5039);
    tick(1);
    chk("lit_start_single", eng_start_o, 0);
    get_rsp(0, 1, 64'd13, 1'b0);

    // Engine answers in the last WAIT cycle: valid beats the watchdog
    eng_delay = 8;
    send(2, 64'd9000);
    get_rsp(0, 2, 64'd2342, 1'b0);

    // Hung engine: watchdog error
    eng_delay = 0;
    send(3, 64'd55);
    k_lat = 0; got_v = 0;
    for (int c = 0; c < 30 && !got_v; c++) begin
      @(negedge clk_i);
      if (rsp_valid_o) got_v = 1; else k_lat++;
    end
    chk("lit_timeout_latency", k_lat, 9);
    get_rsp(0, 3, 64'd0, 1'b1);

    // All requesters valid: round-robin order
    eng_delay = 2;
    base = m_grants.size();
    for (int i = 0; i < N; i++) req_x_i[i*DL +: DL] = 64'(i + 100);
    rsp_ready_i = 1'b1;
    req_valid_i = '1;
    n_gr = 0;
    for (int c = 0; c < 300 && n_gr < 5; c++) begin
      @(negedge clk_i);
      if (req_ready_o != 0) n_gr++;
    end
    @(posedge clk_i); #1;
    req_valid_i = '0;
    chk("rr_grants_seen", n_gr, 5);
    idle_v = 0;
    for (int c = 0; c < 50 && !idle_v; c++) begin
      @(negedge clk_i);
      if (!cfg_busy_o) idle_v = 1;
    end
    chk("rr_drain", idle_v, 1);
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    for (int k = 0; k < 5; k++)
      chk("lit_grant_order", (m_grants.size() > base + k) ? m_grants[base + k] : -1, exp_order[k]);

    // Response back-pressure with another requester waiting
    eng_delay = 1;
    send(0, 64'd4000);
    req_x_i[1*DL +: DL] = 64'd500;
    req_valid_i[1] = 1'b1;
    get_rsp(5, 0, 64'd671, 1'b0);
    send(1, 64'd500);
    get_rsp(0, 1, 64'd500, 1'b0);

    // Config write during WAIT is dropped
    eng_delay = 4;
    send(0, 64'd10000);
    tick(1);
    chk("lit_busy_in_wait", cfg_busy_o, 1);
    do_cfg(64'd7681, 64'd13, 64'd1234);
    get_rsp(0, 0, 64'd13, 1'b0);

    // Config write coincident with a handshake applies to the following job
    cfg_q_i = 64'd7681; cfg_q_bl_i = 64'd13; cfg_mu_i = 64'd1234; cfg_we_i = 1'b1;
    req_x_i[2*DL +: DL] = 64'd10000;
    req_valid_i[2] = 1'b1;
    @(negedge clk_i);
    chk("lit_coincident_ready", req_ready_o, 4'b0100);
    @(posedge clk_i); #1;
    cfg_we_i = 1'b0;
    req_valid_i[2] = 1'b0;
    chk("lit_old_q", eng_q_o, 64'd3329);
    get_rsp(0, 2, 64'd13, 1'b0);
    send(3, 64'd10000);
    chk("lit_new_q", eng_q_o, 64'd7681);
    get_rsp(0, 3, 64'd2319, 1'b0);

    // Reset in WAIT
    eng_delay = 0;
    send(1, 64'd777);
    tick(2);
    req_valid_i[2] = 1'b1;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("lit_arst_busy", cfg_busy_o, 0);
    chk("lit_arst_ready", req_ready_o, 0);
    chk("lit_arst_start", eng_start_o, 0);
    chk("lit_arst_x", eng_x_o, 0);
    chk("lit_arst_q", eng_q_o, 0);
    chk("lit_arst_rsp_valid", rsp_valid_o, 0);
    chk("lit_arst_rsp_id", rsp_id_o, 0);
    chk("lit_arst_rsp_data", rsp_data_o, 0);
    chk("lit_arst_rsp_err", rsp_err_o, 0);
    req_valid_i = '0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    tick(1);
    do_cfg(64'd3329, 64'd12, 64'd5039);
    eng_delay = 2;
    req_x_i[0*DL +: DL] = 64'd1;
    req_x_i[3*DL +: DL] = 64'd3;
    req_valid_i = 4'b1001;
    @(negedge clk_i);
    chk("lit_post_reset_prio", req_ready_o, 4'b0001);
    @(posedge clk_i); #1;
    req_valid_i[0] = 1'b0;
    get_rsp(0, 0, 64'd1, 1'b0);
    send(3, 64'd3);
    get_rsp(0, 3, 64'd3, 1'b0);

    tick(3);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "bench timeout");
  end

endmodule
